// File: rtl/seq_pkg.sv
// Shared types and constants for the seq_scan_arb slice.
// Holds the scheduler FSM state enum, the "101" detector state encodings
// and the number of zero pad bits used to flush the detector after a word.
package seq_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Detector states, named by the suffix of "101" matched so far
  typedef enum logic [1:0] {
    S0   = 2'b00,
    S1   = 2'b01,
    S10  = 2'b10,
    S101 = 2'b11
  } det_state_e;

  // Zero pad bits shifted after the word to cover the detector's latency
  localparam int unsigned DRAIN_LEN = 2;

endpackage : seq_pkg

// File: rtl/seq_scan_arb_if.sv
// Handshake bundle for seq_scan_arb.
// Ports:
//   req0_valid/req0_data/req0_ready : requester 0 word handshake
//   req1_valid/req1_data/req1_ready : requester 1 word handshake
//   rsp_valid/rsp_ready             : response handshake
//   rsp_id                          : requester that owns the response
//   rsp_count                       : number of "101" detections in the word
// The master modport is the producer/consumer side; the slave modport is
// the scheduler.
interface seq_scan_arb_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) ();

  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [CW-1:0]    rsp_count;

  modport master (
    output req0_valid,
    output req0_data,
    input  req0_ready,
    output req1_valid,
    output req1_data,
    input  req1_ready,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_id,
    input  rsp_count
  );

  modport slave (
    input  req0_valid,
    input  req0_data,
    output req0_ready,
    input  req1_valid,
    input  req1_data,
    output req1_ready,
    output rsp_valid,
    input  rsp_ready,
    output rsp_id,
    output rsp_count
  );

endinterface : seq_scan_arb_if

// File: rtl/seq_det_core.sv
// Serial "101" detector with restart-after-match.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force S0 and det=0 (priority over en)
//   en         : advance the detector by one bit
//   in         : serial input bit
//   det        : registered match flag, high one cycle, two en edges after
//                the completing bit is sampled
module seq_det_core
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic in,
  output logic det
);

  det_state_e state;
  det_state_e state_nxt;

  // State and det register; det reflects the state before this en edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S0;
      det   <= 1'b0;
    end else if (clr) begin
      state <= S0;
      det   <= 1'b0;
    end else if (en) begin
      state <= state_nxt;
      det   <= (state == S101);
    end
  end

  // Next state; a 0 after a match drops to S0 so the trailing 1 is not reused
  always_comb begin
    state_nxt = state;
    case (state)
      S0:      state_nxt = in ? S1   : S0;
      S1:      state_nxt = in ? S1   : S10;
      S10:     state_nxt = in ? S101 : S0;
      S101:    state_nxt = in ? S1   : S0;
      default: state_nxt = S0;
    endcase
  end

endmodule : seq_det_core

// File: rtl/seq_scan_arb.sv
// Two-requester round-robin scheduler around one serial "101" detector.
// A granted word is shifted MSB-first through seq_det_core, followed by
// DRAIN_LEN zero pad bits, and the detection count is returned with the
// requester ID over the response handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seq_scan_arb_if slave (requests in, response out)
module seq_scan_arb
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  seq_scan_arb_if.slave bus
);

  localparam int unsigned BCW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = '1;

  arb_state_e       state;
  arb_state_e       state_nxt;

  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0]   bit_cnt;
  logic [CW-1:0]    count;
  logic             last_grant;
  logic             id_q;
  logic             rsp_valid_q;

  logic             gnt0;
  logic             gnt1;
  logic             ready0;
  logic             ready1;
  logic             take;
  logic             bit_last;
  logic             drain_last;
  logic             core_clr;
  logic             core_en;
  logic             core_in;
  logic             det;

  // Round-robin grant: a lone requester wins, a contest goes to the other one
  always_comb begin
    gnt0 = bus.req0_valid & (~bus.req1_valid | last_grant);
    gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
  end

  assign bit_last   = (bit_cnt == BCW'(WIDTH - 1));
  assign drain_last = (bit_cnt == BCW'(DRAIN_LEN - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and core/handshake controls
  always_comb begin
    state_nxt = state;
    ready0    = 1'b0;
    ready1    = 1'b0;
    take      = 1'b0;
    core_clr  = 1'b0;
    core_en   = 1'b0;
    core_in   = 1'b0;
    case (state)
      IDLE: begin
        // rst_n gating keeps both readies low while reset is asserted
        ready0 = rst_n & gnt0;
        ready1 = rst_n & gnt1;
        take   = ready0 | ready1;
        if (take) begin
          core_clr  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        core_en = 1'b1;
        core_in = shreg[WIDTH-1];
        if (bit_last) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        core_en = 1'b1;
        if (drain_last) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Word capture, shifting, bit/pad counting and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      count       <= '0;
      last_grant  <= 1'b1;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            shreg      <= ready1 ? bus.req1_data : bus.req0_data;
            id_q       <= ready1;
            last_grant <= ready1;
            bit_cnt    <= '0;
            count      <= '0;
          end
        end
        SHIFT: begin
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          bit_cnt <= bit_last ? '0 : bit_cnt + BCW'(1);
        end
        DRAIN: begin
          bit_cnt <= drain_last ? '0 : bit_cnt + BCW'(1);
          if (drain_last) begin
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
        end
      endcase
      // Count is only stepped while the core is being clocked
      if (core_en && det && (count != CNT_MAX)) begin
        count <= count + CW'(1);
      end
    end
  end

  seq_det_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (core_clr),
    .en    (core_en),
    .in    (core_in),
    .det   (det)
  );

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_count  = count;

endmodule : seq_scan_arb

// File: tb/tb_seq_scan_arb.sv
// Self-checking bench for seq_scan_arb: directed steps plus random words,
// with a reference model of the grant order and the detection count.
module tb_seq_scan_arb;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_fail;
  bit mdl_last;
  logic [W-1:0] d0;
  logic [W-1:0] d1;

  seq_scan_arb_if #(.WIDTH(W), .CW(CW)) bus ();

  seq_scan_arb #(.WIDTH(W), .CW(CW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leftmost non-overlapping occurrences of "101" scanned MSB-first
  function automatic int model_count(input logic [W-1:0] w);
    int c;
    int i;
    c = 0;
    i = W - 1;
    while (i >= 2) begin
      if (w[i] && !w[i-1] && w[i-2]) begin
        c++;
        i -= 3;
      end else begin
        i--;
      end
    end
    return c;
  endfunction

  // Serve one word from the currently driven requests; called at a negedge
  task automatic serve(input int stall, input bit keep, input logic [W-1:0] next_data);
    int waited;
    int lat;
    int bad_ready;
    bit got;
    bit exp_id;
    logic [W-1:0] exp_data;
    int exp_cnt;
    exp_id   = (bus.req0_valid && bus.req1_valid) ? !mdl_last : bus.req1_valid;
    exp_data = exp_id ? d1 : d0;
    exp_cnt  = model_count(exp_data);
    bus.rsp_ready = (stall == 0);
    waited = 0;
    #1;
    while (!(bus.req0_ready || bus.req1_ready) && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("grant_seen", 32'(bus.req0_ready | bus.req1_ready), 1);
    if (!(bus.req0_ready || bus.req1_ready)) return;
    check("grant_sel", {bus.req0_ready, bus.req1_ready}, exp_id ? 2'b01 : 2'b10);
    mdl_last = exp_id;
    @(negedge clk);
    if (keep) begin
      if (exp_id) begin d1 = next_data; bus.req1_data = d1; end
      else        begin d0 = next_data; bus.req0_data = d0; end
    end else begin
      if (exp_id) bus.req1_valid = 1'b0;
      else        bus.req0_valid = 1'b0;
    end
    lat = 0;
    got = 0;
    bad_ready = 0;
    while (lat < 40) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) bad_ready++;
      if (bus.rsp_valid) begin
        got = 1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    check("busy_ready", bad_ready, 0);
    check("rsp_seen", 32'(got), 1);
    if (!got) return;
    check("latency", lat, W + 2);
    check("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
    check("rsp_count", 32'(bus.rsp_count), exp_cnt);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      check("stall_valid", 32'(bus.rsp_valid), 1);
      check("stall_id", 32'(bus.rsp_id), 32'(exp_id));
      check("stall_count", 32'(bus.rsp_count), exp_cnt);
      check("stall_ready", {bus.req0_ready, bus.req1_ready}, 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("rsp_drop", 32'(bus.rsp_valid), 0);
    if (bus.req0_valid || bus.req1_valid)
      check("accept_next", 32'(bus.req0_ready | bus.req1_ready), 1);
  endtask

  initial begin
    int idle_bad;
    int pat;
    n_cmp  = 0;
    n_fail = 0;

    // Reset with both requesters valid
    rst_n = 1'b0;
    mdl_last = 1'b1;
    d0 = '0;
    d1 = '0;
    bus.req0_data  = d0;
    bus.req1_data  = d1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.rsp_ready  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready0", 32'(bus.req0_ready), 0);
    check("rst_ready1", 32'(bus.req1_ready), 0);
    check("rst_valid", 32'(bus.rsp_valid), 0);
    check("rst_id", 32'(bus.rsp_id), 0);
    check("rst_count", 32'(bus.rsp_count), 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Restart-after-match word from requester 0
    d0 = 8'b10101101; bus.req0_data = d0; bus.req0_valid = 1'b1;
    serve(0, 0, '0);

    // Three words from requester 1
    d1 = 8'hFF;       bus.req1_data = d1; bus.req1_valid = 1'b1; serve(0, 0, '0);
    d1 = 8'b01010101; bus.req1_data = d1; bus.req1_valid = 1'b1; serve(0, 0, '0);
    d1 = 8'b10100000; bus.req1_data = d1; bus.req1_valid = 1'b1; serve(0, 0, '0);

    // Both requesters held valid: grants alternate
    d0 = W'($urandom); bus.req0_data = d0;
    d1 = W'($urandom); bus.req1_data = d1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) serve(0, 1, W'($urandom));
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Response stalled for 5 cycles
    d0 = W'($urandom); bus.req0_data = d0; bus.req0_valid = 1'b1;
    serve(5, 0, '0);

    // Reset in the middle of a word
    d1 = 8'b10100000; bus.req1_data = d1; bus.req1_valid = 1'b1;
    #1;
    check("mid_grant", 32'(bus.req1_ready), 1);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("mid_count", 32'(bus.rsp_count), 1);
    check("mid_id", 32'(bus.rsp_id), 1);
    d0 = 8'b00000101; bus.req0_data = d0; bus.req0_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(bus.rsp_valid), 0);
    check("mrst_id", 32'(bus.rsp_id), 0);
    check("mrst_count", 32'(bus.rsp_count), 0);
    check("mrst_ready", {bus.req0_ready, bus.req1_ready}, 0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;
    mdl_last = 1'b1;
    idle_bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid !== 1'b0) idle_bad++;
    end
    check("no_orphan_rsp", idle_bad, 0);
    bus.req0_valid = 1'b1;
    serve(0, 0, '0);

    // Back-to-back words from requester 0
    d0 = 8'b01011010; bus.req0_data = d0; bus.req0_valid = 1'b1;
    serve(0, 1, 8'b01011010);
    serve(0, 0, '0);

    // Random request patterns, data and stalls
    for (int k = 0; k < 16; k++) begin
      pat = int'($urandom_range(1, 3));
      d0 = W'($urandom); bus.req0_data = d0;
      d1 = W'($urandom); bus.req1_data = d1;
      bus.req0_valid = pat[0];
      bus.req1_valid = pat[1];
      serve(int'($urandom_range(0, 2)), 0, '0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_seq_scan_arb
